// File: rtl/dds_spi_master.sv
// -----------------------------------------------------------------------------
// dds_spi_master
//
// Serialises a parallel frequency or phase-shift word onto the DDS core's SPI
// inputs. The host issues a single valid/ready command; the block then emits
// one framed transfer (MSB first) with spi_clk generated by dividing i_sys_clk.
// The frame ends with a chip-select hold, the CS falling edge that loads the
// DDS register, and a quiet gap before the next command is taken.
//
// Ports
//   i_sys_clk        system clock, all logic on its rising edge
//   i_rst            asynchronous active-high reset
//   i_cmd_valid      command request
//   i_cmd_sel        0 = frequency word, 1 = phase-shift word
//   i_cmd_word       payload (phase commands use [PHASE_LENGTH-1:0])
//   o_cmd_ready      high when idle; accept on i_cmd_valid && o_cmd_ready
//   o_done           one-cycle pulse when a frame has completed
//   o_spi_clk        serial clock to the DDS
//   o_spi_data       serial data, MSB first
//   o_freq_cs        active-high frame enable, frequency register
//   o_phaseshift_cs  active-high frame enable, phase register
//
// Timing model: the state register moves on the acceptance edge, and every
// output is a registered decode of the current state, so the pins trail the
// state by exactly one i_sys_clk cycle. That lag puts CS and the first bit on
// edge 1 after acceptance, as the DDS frame timing expects.
// -----------------------------------------------------------------------------
module dds_spi_master #(
    parameter int FREQ_LENGTH  = 48,
    parameter int PHASE_LENGTH = 16,
    parameter int CLK_DIV      = 2
) (
    input  logic                   i_sys_clk,
    input  logic                   i_rst,
    input  logic                   i_cmd_valid,
    input  logic                   i_cmd_sel,
    input  logic [FREQ_LENGTH-1:0] i_cmd_word,
    output logic                   o_cmd_ready,
    output logic                   o_done,
    output logic                   o_spi_clk,
    output logic                   o_spi_data,
    output logic                   o_freq_cs,
    output logic                   o_phaseshift_cs
);

    localparam int BIT_W = (FREQ_LENGTH > 1) ? $clog2(FREQ_LENGTH) : 1;
    // Divider must reach 2*CLK_DIV-1 for the gap phase.
    localparam int DIV_W = $clog2(2 * CLK_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    // Control / datapath registers
    state_t                 r_state;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [FREQ_LENGTH-1:0] r_shift;
    logic                   r_sel;

    // Output registers
    logic r_cmd_ready;
    logic r_done;
    logic r_spi_clk;
    logic r_spi_data;
    logic r_freq_cs;
    logic r_phaseshift_cs;

    // Combinational signals
    state_t                 w_state_next;
    logic                   w_accept;
    logic [DIV_W-1:0]       w_div_limit;
    logic                   w_div_end;
    logic [FREQ_LENGTH-1:0] w_phase_aligned;
    logic                   w_in_frame;
    logic                   w_cmd_ready_next;
    logic                   w_done_next;
    logic                   w_spi_clk_next;
    logic                   w_spi_data_next;
    logic                   w_freq_cs_next;
    logic                   w_phaseshift_cs_next;

    // r_cmd_ready is only ever high while r_state is IDLE, so this alone
    // qualifies acceptance.
    assign w_accept = i_cmd_valid && r_cmd_ready;

    // The gap phase lasts two half-periods, every other timed phase one.
    assign w_div_limit = (r_state == S_GAP) ? DIV_W'(2 * CLK_DIV - 1)
                                            : DIV_W'(CLK_DIV - 1);
    assign w_div_end   = (r_div_cnt == w_div_limit);

    // A phase word is left-aligned so the shifter's MSB is always the bit on
    // the wire, independent of the command type.
    assign w_phase_aligned = FREQ_LENGTH'(i_cmd_word[PHASE_LENGTH-1:0])
                             << (FREQ_LENGTH - PHASE_LENGTH);

    // ---------------------------------------------------------------------
    // State register and frame datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_sel     <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Divider restarts on every state change and is parked in IDLE.
            if (r_state == S_IDLE || w_state_next != r_state) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end

            if (w_accept) begin
                r_sel     <= i_cmd_sel;
                r_shift   <= i_cmd_sel ? w_phase_aligned : i_cmd_word;
                r_bit_cnt <= i_cmd_sel ? BIT_W'(PHASE_LENGTH - 1)
                                       : BIT_W'(FREQ_LENGTH - 1);
            end else if (r_state == S_HIGH && w_div_end && r_bit_cnt != '0) begin
                // Advance to the next bit at the end of the high phase; the
                // registered output lag makes it appear with the spi_clk fall.
                r_shift   <= r_shift << 1;
                r_bit_cnt <= r_bit_cnt - BIT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (w_div_end) begin
                    w_state_next = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_div_end) begin
                    w_state_next = (r_bit_cnt == '0) ? S_HOLD : S_LOW;
                end
            end
            S_HOLD: begin
                if (w_div_end) begin
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (w_div_end) begin
                    w_state_next = S_DONE;
                end
            end
            // Single cycle that raises done/ready one edge later.
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output decode (registered below)
    // ---------------------------------------------------------------------
    always_comb begin
        w_in_frame           = (r_state == S_LOW) || (r_state == S_HIGH) ||
                               (r_state == S_HOLD);
        w_cmd_ready_next     = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                               !w_accept;
        w_done_next          = (r_state == S_DONE);
        w_spi_clk_next       = (r_state == S_HIGH);
        // Data follows the shifter only while bits are being clocked; outside
        // that it holds, so it never moves except at a fall or frame start.
        w_spi_data_next      = r_spi_data;
        if (r_state == S_LOW || r_state == S_HIGH) begin
            w_spi_data_next = r_shift[FREQ_LENGTH-1];
        end
        w_freq_cs_next       = w_in_frame && !r_sel;
        w_phaseshift_cs_next = w_in_frame &&  r_sel;
    end

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cmd_ready     <= 1'b1;
            r_done          <= 1'b0;
            r_spi_clk       <= 1'b0;
            r_spi_data      <= 1'b0;
            r_freq_cs       <= 1'b0;
            r_phaseshift_cs <= 1'b0;
        end else begin
            r_cmd_ready     <= w_cmd_ready_next;
            r_done          <= w_done_next;
            r_spi_clk       <= w_spi_clk_next;
            r_spi_data      <= w_spi_data_next;
            r_freq_cs       <= w_freq_cs_next;
            r_phaseshift_cs <= w_phaseshift_cs_next;
        end
    end

    assign o_cmd_ready     = r_cmd_ready;
    assign o_done          = r_done;
    assign o_spi_clk       = r_spi_clk;
    assign o_spi_data      = r_spi_data;
    assign o_freq_cs       = r_freq_cs;
    assign o_phaseshift_cs = r_phaseshift_cs;

endmodule

// File: tb/tb_dds_spi_master.sv
// -----------------------------------------------------------------------------
// tb_dds_spi_master
//
// Scoreboarded bench for dds_spi_master. The stimulus side pushes the command
// it expects to see framed (with its acceptance edge) into a queue; an
// independent negedge monitor rebuilds each frame from the SPI pins and checks
// the word, bit count, CS choice and edge timing against arithmetic derived
// from the frame timing rules.
// -----------------------------------------------------------------------------
module tb_dds_spi_master;

    localparam int FL = 48;
    localparam int PL = 16;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic          sel = 1'b0;
    logic [FL-1:0] word = '0;
    logic          o_cmd_ready, o_done, o_spi_clk, o_spi_data;
    logic          o_freq_cs, o_phaseshift_cs;

    dds_spi_master #(
        .FREQ_LENGTH (FL),
        .PHASE_LENGTH(PL),
        .CLK_DIV     (D)
    ) dut (
        .i_sys_clk      (clk),
        .i_rst          (rst),
        .i_cmd_valid    (valid),
        .i_cmd_sel      (sel),
        .i_cmd_word     (word),
        .o_cmd_ready    (o_cmd_ready),
        .o_done         (o_done),
        .o_spi_clk      (o_spi_clk),
        .o_spi_data     (o_spi_data),
        .o_freq_cs      (o_freq_cs),
        .o_phaseshift_cs(o_phaseshift_cs)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; edge k is the k-th posedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          s;
        logic [FL-1:0] w;
        int            acc;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference frame length in sys_clk edges from acceptance to done.
    function automatic int frame_len(input logic s);
        int n;
        n = s ? PL : FL;
        return 1 + 2 * D * n + 3 * D;
    endfunction

    // ---------------------------------------------------------------------
    // Monitor / scoreboard
    // ---------------------------------------------------------------------
    logic [63:0] m_bits;
    int          m_nb;
    int          m_cs_rise, m_cs_fall, m_first_rise;
    logic        m_used_sel;
    logic        m_overlap, m_data_bad;
    logic        p_sclk, p_sdata, p_fcs, p_pcs;
    int          last_done_edge = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_bits = '0; m_nb = 0; m_cs_rise = -1; m_cs_fall = -1;
            m_first_rise = -1; m_used_sel = 1'b0;
            m_overlap = 1'b0; m_data_bad = 1'b0;
            p_sclk = o_spi_clk; p_sdata = o_spi_data;
            p_fcs = o_freq_cs; p_pcs = o_phaseshift_cs;
        end else begin
            logic cs_now, cs_prev, cs_rose, sclk_fell;
            cs_now    = o_freq_cs || o_phaseshift_cs;
            cs_prev   = p_fcs || p_pcs;
            cs_rose   = cs_now && !cs_prev;
            sclk_fell = p_sclk && !o_spi_clk;

            if (o_freq_cs && o_phaseshift_cs) m_overlap = 1'b1;
            if (cs_rose) begin
                m_cs_rise = cyc; m_used_sel = o_phaseshift_cs;
                m_bits = '0; m_nb = 0; m_first_rise = -1; m_data_bad = 1'b0;
            end
            if (!cs_now && cs_prev) m_cs_fall = cyc;
            if (o_spi_data !== p_sdata && !sclk_fell && !cs_rose) m_data_bad = 1'b1;
            if (o_spi_clk && !p_sclk) begin
                m_bits = {m_bits[62:0], o_spi_data};
                m_nb++;
                if (m_first_rise < 0) m_first_rise = cyc;
            end

            if (o_done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: got done=1 at edge %0d required done=0", cyc);
                end else begin
                    exp_t e;
                    int n;
                    logic [63:0] expw;
                    e = exp_q.pop_front();
                    n = e.s ? PL : FL;
                    expw = e.s ? 64'(e.w[PL-1:0]) : 64'(e.w);
                    check("word",        longint'(m_bits), longint'(expw));
                    check("nbits",       longint'(m_nb), longint'(n));
                    check("cs_select",   longint'(m_used_sel), longint'(e.s));
                    check("cs_rise",     longint'(m_cs_rise), longint'(e.acc + 1));
                    check("first_sclk",  longint'(m_first_rise), longint'(e.acc + 1 + D));
                    check("cs_fall",     longint'(m_cs_fall), longint'(e.acc + 1 + 2 * D * n + D));
                    check("done_edge",   longint'(cyc), longint'(e.acc + frame_len(e.s)));
                    check("ready_at_done", longint'(o_cmd_ready), 64'sd1);
                    check("cs_overlap",  longint'(m_overlap), 64'sd0);
                    check("data_edges",  longint'(m_data_bad), 64'sd0);
                    $display("frame sel=%0d acc=%0d done=%0d exp=%h got=%h bits=%0d",
                             e.s, e.acc, cyc, expw, m_bits, m_nb);
                    m_overlap = 1'b0;
                end
                last_done_edge = cyc;
            end
            p_sclk = o_spi_clk; p_sdata = o_spi_data;
            p_fcs = o_freq_cs; p_pcs = o_phaseshift_cs;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    function automatic logic [FL-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[FL-1:0];
    endfunction

    // Presents a command and waits (bounded) for acceptance. Afterwards the
    // command inputs are scrambled to show they no longer matter.
    task automatic send(input logic s, input logic [FL-1:0] w, input bit keep_valid,
                        output int acc);
        bit ok;
        ok = 1'b0;
        acc = -1;
        @(negedge clk);
        sel = s; word = w; valid = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            if (o_cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 64'sd0, 64'sd1);
            valid = 1'b0;
        end else begin
            exp_t e;
            acc = cyc + 1;
            e.s = s; e.w = w; e.acc = acc;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            if (!keep_valid) valid = 1'b0;
            sel = 1'($urandom); word = rand_word();
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            check("frame_timeout", longint'(exp_q.size()), 64'sd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_busy();
        @(negedge clk);
        if (!o_cmd_ready) begin
            valid = 1'b1; sel = 1'($urandom); word = rand_word();
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    initial begin
        int acc, prev_acc;
        logic prev_s;

        // Reset and idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs",
                  longint'({o_cmd_ready, o_done, o_spi_clk, o_spi_data, o_freq_cs, o_phaseshift_cs}),
                  64'sh20);
        end

        // Directed frequency and phase frames.
        send(1'b0, 48'h8000_0000_0001, 1'b0, acc);
        wait_idle();
        send(1'b1, {32'hDEAD_BEEF, 16'hA5C3}, 1'b0, acc);
        wait_idle();

        // Valid pulsed while busy must be ignored.
        send(1'b0, rand_word(), 1'b0, acc);
        repeat (30) @(negedge clk);
        pulse_busy();
        repeat (40) @(negedge clk);
        pulse_busy();
        wait_idle();

        // Back-to-back with valid held high and alternating select.
        prev_s = 1'b1;
        send(prev_s, rand_word(), 1'b1, prev_acc);
        for (int i = 0; i < 4; i++) begin
            logic s;
            s = ~prev_s;
            send(s, rand_word(), (i != 3), acc);
            check("b2b_accept", longint'(acc), longint'(prev_acc + frame_len(prev_s) + 1));
            prev_acc = acc; prev_s = s;
        end
        wait_idle();

        // Random frames with random idle spacing.
        for (int i = 0; i < 8; i++) begin
            send(1'($urandom), rand_word(), 1'b0, acc);
            wait_idle();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // Reset at edge 40 of a frequency frame.
        send(1'b0, rand_word(), 1'b0, acc);
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #2;
            if (cyc >= acc + 40) break;
        end
        rst = 1'b1;
        #1;
        check("async_reset",
              longint'({o_cmd_ready, o_done, o_spi_clk, o_spi_data, o_freq_cs, o_phaseshift_cs}),
              64'sh20);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send(1'b0, rand_word(), 1'b0, acc);
        wait_idle();
        send(1'b1, rand_word(), 1'b0, acc);
        wait_idle();

        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
